// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer driving an external single-bit full-adder cell, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_c,
   input  logic             fa_sum,
   input  logic             fa_carry
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           stateQ;
   logic [WIDTH-1:0] aQ;
   logic [WIDTH-1:0] bQ;
   logic [WIDTH-1:0] resQ;
   logic [WIDTH-1:0] sumQ;
   logic             carryQ;
   logic             coutQ;
   logic             busyQ;
   logic             doneQ;
   logic [CW-1:0]    cntQ;

   logic [WIDTH-1:0] resD;
   logic [WIDTH-1:0] bLoadD;
   logic             carryLoadD;
   logic             lastBitD;

   always_comb begin
      resD     = (resQ >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
      lastBitD = (cntQ == CW'(WIDTH - 1));
`ifdef SERIAL_ADD_SUB_EN
      bLoadD     = sub ? ~b : b;
      carryLoadD = sub ? 1'b1 : cin;
`else
      bLoadD     = b;
      carryLoadD = cin;
`endif
   end

   // Operand and carry registers are left at zero outside RUN, so the
   // full-adder inputs can come straight from them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateQ <= IDLE;
         aQ     <= '0;
         bQ     <= '0;
         resQ   <= '0;
         sumQ   <= '0;
         carryQ <= 1'b0;
         coutQ  <= 1'b0;
         busyQ  <= 1'b0;
         doneQ  <= 1'b0;
         cntQ   <= '0;
      end else begin
         doneQ <= 1'b0;
         case (stateQ)
            IDLE, DONE: begin
               if (start) begin
                  aQ     <= a;
                  bQ     <= bLoadD;
                  carryQ <= carryLoadD;
                  resQ   <= '0;
                  cntQ   <= '0;
                  busyQ  <= 1'b1;
                  stateQ <= RUN;
               end else begin
                  stateQ <= IDLE;
               end
            end
            RUN: begin
               aQ     <= aQ >> 1;
               bQ     <= bQ >> 1;
               resQ   <= resD;
               carryQ <= fa_carry;
               cntQ   <= cntQ + CW'(1);
               if (lastBitD) begin
                  sumQ   <= resD;
                  coutQ  <= fa_carry;
                  carryQ <= 1'b0;
                  cntQ   <= '0;
                  busyQ  <= 1'b0;
                  doneQ  <= 1'b1;
                  stateQ <= DONE;
               end
            end
            default: begin
               stateQ <= IDLE;
            end
         endcase
      end
   end

   assign busy = busyQ;
   assign done = doneQ;
   assign sum  = sumQ;
   assign cout = coutQ;
   assign fa_a = aQ[0];
   assign fa_b = bQ[0];
   assign fa_c = carryQ;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1, with a behavioural full-adder cell.
// Subtract scenarios are compiled in when SERIAL_ADD_SUB_EN is defined.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       cin8;
   logic       sub8;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;
   logic       faA8;
   logic       faB8;
   logic       faC8;
   logic       faSum8;
   logic       faCarry8;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       cin1;
   logic       sub1;
   logic       busy1;
   logic       done1;
   logic [0:0] sum1;
   logic       cout1;
   logic       faA1;
   logic       faB1;
   logic       faC1;
   logic       faSum1;
   logic       faCarry1;

   // Lab full-adder cells
   assign faSum8   = faA8 ^ faB8 ^ faC8;
   assign faCarry8 = (faA8 & faB8) | (faA8 & faC8) | (faB8 & faC8);
   assign faSum1   = faA1 ^ faB1 ^ faC1;
   assign faCarry1 = (faA1 & faB1) | (faA1 & faC1) | (faB1 & faC1);

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start8),
      .a        (a8),
      .b        (b8),
      .cin      (cin8),
`ifdef SERIAL_ADD_SUB_EN
      .sub      (sub8),
`endif
      .busy     (busy8),
      .done     (done8),
      .sum      (sum8),
      .cout     (cout8),
      .fa_a     (faA8),
      .fa_b     (faB8),
      .fa_c     (faC8),
      .fa_sum   (faSum8),
      .fa_carry (faCarry8)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start1),
      .a        (a1),
      .b        (b1),
      .cin      (cin1),
`ifdef SERIAL_ADD_SUB_EN
      .sub      (sub1),
`endif
      .busy     (busy1),
      .done     (done1),
      .sum      (sum1),
      .cout     (cout1),
      .fa_a     (faA1),
      .fa_b     (faB1),
      .fa_c     (faC1),
      .fa_sum   (faSum1),
      .fa_carry (faCarry1)
   );

   int testsRun    = 0;
   int testsFailed = 0;

   logic [8:0] expQ8[$];
   logic [1:0] expQ1[$];

   logic [7:0] curA;
   logic [7:0] curB;
   logic       curC;
   logic [7:0] holdSum;
   logic       holdCout;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                input logic cv, input logic sv);
      logic [7:0] bEff;
      logic       cEff;
      bEff = sv ? ~bv : bv;
      cEff = sv ? 1'b1 : cv;
      expQ8.push_back({1'b0, av} + {1'b0, bEff} + {8'b0, cEff});
      curA     = av;
      curB     = bEff;
      curC     = cEff;
      holdSum  = sum8;
      holdCout = cout8;
      a8       = av;
      b8       = bv;
      cin8     = cv;
      sub8     = sv;
      start8   = 1'b1;
      step();
      start8   = 1'b0;
   endtask

   // Walks the RUN phase checking each full-adder input bit and the held
   // result, then pops the scoreboard once done appears.
   task automatic checkOutput(input string name, input int pulseAt);
      int         steps;
      int         busyCnt;
      int         faErr;
      logic       c;
      bit         seen;
      logic [8:0] exp;
      steps   = 1;
      busyCnt = 0;
      faErr   = 0;
      c       = curC;
      seen    = 1'b0;
      while (!seen && steps <= 20) begin
         if (done8 === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (busy8 === 1'b1) begin
               if (busyCnt < 8) begin
                  if (faA8 !== curA[busyCnt] || faB8 !== curB[busyCnt] || faC8 !== c)
                     faErr++;
                  c = (curA[busyCnt] & curB[busyCnt]) | (curA[busyCnt] & c) | (curB[busyCnt] & c);
               end
               if (sum8 !== holdSum || cout8 !== holdCout)
                  faErr++;
               busyCnt++;
            end else begin
               faErr++;
            end
            if (steps == pulseAt) begin
               start8 = 1'b1;
               a8     = 8'h00;
               b8     = 8'h00;
            end
            step();
            start8 = 1'b0;
            steps++;
         end
      end
      testsRun++;
      if (!seen || steps !== 9) begin
         testsFailed++;
         $display("[TB] FAIL %s done cycle: got %0d (seen=%0d), expected 9", name, steps, seen);
      end
      testsRun++;
      if (busyCnt !== 8) begin
         testsFailed++;
         $display("[TB] FAIL %s busy cycles: got %0d, expected 8", name, busyCnt);
      end
      testsRun++;
      if (faErr !== 0) begin
         testsFailed++;
         $display("[TB] FAIL %s fa inputs/held result: got %0d errors, expected 0", name, faErr);
      end
      exp = expQ8.pop_front();
      testsRun++;
      if ({cout8, sum8} !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s result: got cout=%0b sum=%h, expected cout=%0b sum=%h",
                  name, cout8, sum8, exp[8], exp[7:0]);
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      start8 = 1'b0;
      start1 = 1'b0;
      a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      testsRun++;
      if ({busy8, done8, cout8, faA8, faB8, faC8} !== 6'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset ctrl8: got %b, expected 000000", {busy8, done8, cout8, faA8, faB8, faC8});
      end
      testsRun++;
      if (sum8 !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL reset sum8: got %h, expected 00", sum8);
      end
      testsRun++;
      if ({busy1, done1, cout1, sum1, faA1, faB1, faC1} !== 7'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset ctrl1: got %b, expected 0000000", {busy1, done1, cout1, sum1, faA1, faB1, faC1});
      end
      step();
      testsRun++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL idle hold: got busy=%0b done=%0b, expected 0 0", busy8, done8);
      end
   endtask

   task automatic test_add();
      applyStimulus(8'h3C, 8'h5A, 1'b0, 1'b0);
      checkOutput("add 3C+5A", 0);
      step();
      testsRun++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h96) begin
         testsFailed++;
         $display("[TB] FAIL add after done: got done=%0b busy=%0b sum=%h, expected 0 0 96", done8, busy8, sum8);
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
      checkOutput("add FF+01", 0);
      applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
      checkOutput("b2b FF+FF+1", 0);
      step();
      testsRun++;
      if (done8 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL b2b done pulse width: got %0b, expected 0", done8);
      end
   endtask

   task automatic test_start_ignored();
      int doneCnt;
      applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
      checkOutput("start ignored in RUN", 4);
      doneCnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done8 === 1'b1) doneCnt++;
      end
      testsRun++;
      if (doneCnt !== 0) begin
         testsFailed++;
         $display("[TB] FAIL start ignored extra done: got %0d, expected 0", doneCnt);
      end
   endtask

   task automatic test_reset_mid_run();
      int doneCnt;
      applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0);
      void'(expQ8.pop_back());
      for (int i = 0; i < 4; i++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      testsRun++;
      if ({busy8, done8, cout8, faA8, faB8, faC8} !== 6'b0 || sum8 !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL mid-run reset: got ctrl=%b sum=%h, expected 000000 00",
                  {busy8, done8, cout8, faA8, faB8, faC8}, sum8);
      end
      doneCnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done8 === 1'b1 || busy8 === 1'b1) doneCnt++;
      end
      testsRun++;
      if (doneCnt !== 0) begin
         testsFailed++;
         $display("[TB] FAIL mid-run reset activity: got %0d, expected 0", doneCnt);
      end
      applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0);
      checkOutput("after reset A5+3C+1", 0);
   endtask

   task automatic test_width1_sweep();
      logic [2:0] v;
      logic [1:0] exp;
      for (int i = 0; i < 8; i++) begin
         v    = 3'(i);
         a1   = v[2];
         b1   = v[1];
         cin1 = v[0];
         expQ1.push_back({1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]});
         start1 = 1'b1;
         step();
         start1 = 1'b0;
         testsRun++;
         if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL w1 %0d cycle1: got busy=%0b done=%0b, expected 1 0", i, busy1, done1);
         end
         step();
         exp = expQ1.pop_front();
         testsRun++;
         if (done1 !== 1'b1 || {cout1, sum1} !== exp) begin
            testsFailed++;
            $display("[TB] FAIL w1 %0d cycle2: got done=%0b result=%b, expected 1 %b", i, done1, {cout1, sum1}, exp);
         end
      end
      step();
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      applyStimulus(8'h05, 8'h07, 1'b0, 1'b1);
      checkOutput("sub 05-07", 0);
      testsRun++;
      if ({cout8, sum8} !== 9'h0FE) begin
         testsFailed++;
         $display("[TB] FAIL sub 05-07 const: got %h, expected 0FE", {cout8, sum8});
      end
      applyStimulus(8'h07, 8'h05, 1'b1, 1'b1);
      checkOutput("sub 07-05", 0);
      testsRun++;
      if ({cout8, sum8} !== 9'h102) begin
         testsFailed++;
         $display("[TB] FAIL sub 07-05 const: got %h, expected 102", {cout8, sum8});
      end
      sub8 = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid_run();
      test_width1_sweep();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
